// File: rtl/sssp_update_packer.sv
// rtl/sssp_update_packer.sv - compacts per-pipe vertex updates into memory write words
module sssp_update_packer #(
  parameter int               PIPE_NUM = 4,
  parameter int               UPD_W    = 64,
  parameter int               OUT_W    = 512,
  parameter logic [UPD_W-1:0] PAD_VAL  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int               CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIPE_NUM*UPD_W-1:0] upd_data,
  input  logic [PIPE_NUM-1:0]       upd_valid,
  output logic                      upd_ready,
  input  logic                      w_en,
  output logic [OUT_W-1:0]          WData,
  output logic                      WDataV,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [CNT_W-1:0]          word_cnt
);

  localparam int SLOTS = OUT_W / UPD_W;
  localparam int ACC   = 2 * SLOTS - 1;
  localparam int CW    = $clog2(2 * SLOTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [UPD_W-1:0] r_acc       [ACC];
  logic [UPD_W-1:0] w_merged    [ACC];
  logic [UPD_W-1:0] w_acc_nxt   [ACC];
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_n;
  logic [CW-1:0]    w_total;
  logic [CW-1:0]    w_cnt_nxt;
  logic [OUT_W-1:0] r_wdata;
  logic [OUT_W-1:0] w_full_word;
  logic [OUT_W-1:0] w_pad_word;
  logic             r_wdatav;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_out_free;
  logic             w_accept;
  logic             w_load_full;
  logic             w_load_pad;
  logic             w_drain;

  // The output register can take a new word when empty or being drained this cycle.
  assign w_out_free = !r_wdatav || w_en;
  assign upd_ready  = !r_flush_pend && w_out_free;
  assign w_accept   = upd_ready;
  assign w_drain    = r_wdatav && w_en;

  assign WData    = r_wdata;
  assign WDataV   = r_wdatav;
  assign word_cnt = r_word_cnt;

  // Append valid lanes after the current fill level, lowest lane first, skipping invalid lanes.
  always_comb begin
    w_merged = r_acc;
    w_n      = '0;
    for (int i = 0; i < PIPE_NUM; i++) begin
      if (upd_valid[i]) begin
        w_merged[r_cnt + w_n] = upd_data[i*UPD_W +: UPD_W];
        w_n = w_n + CW'(1);
      end
    end
    w_total = r_cnt + w_n;
  end

  // Build the candidate full word from merged slots and the padded flush word from stored slots.
  always_comb begin
    w_full_word = '0;
    w_pad_word  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      w_full_word[k*UPD_W +: UPD_W] = w_merged[k];
      w_pad_word[k*UPD_W +: UPD_W]  = (CW'(k) < r_cnt) ? r_acc[k] : PAD_VAL;
    end
  end

  // Decide whether a full word is emitted and what stays behind in the accumulator.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load_full = 1'b0;
    if (w_accept) begin
      w_acc_nxt = w_merged;
      if (w_total >= CW'(SLOTS)) begin
        w_load_full = 1'b1;
        w_cnt_nxt   = w_total - CW'(SLOTS);
        for (int k = 0; k < SLOTS - 1; k++) begin
          w_acc_nxt[k] = w_merged[k + SLOTS];
        end
      end else begin
        w_cnt_nxt = w_total;
      end
    end
    if (w_load_pad) begin
      w_cnt_nxt = '0;
    end
  end

  // Flush sequencing: push out the partial word, wait for memory to take it, then pulse done.
  always_comb begin
    w_state_nxt = r_state;
    w_load_pad  = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          // Nothing left to pad; skip straight to done if the output is already clear.
          w_state_nxt = w_out_free ? S_DONE : S_WAIT;
        end else if (w_out_free) begin
          w_load_pad  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_out_free) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        flush_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register accumulator, fill level and flush state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      for (int k = 0; k < ACC; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      if (r_state == S_DONE) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Output word register and accepted-word counter; a new load wins over a drain clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdata    <= '0;
      r_wdatav   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_load_full) begin
        r_wdata  <= w_full_word;
        r_wdatav <= 1'b1;
      end else if (w_load_pad) begin
        r_wdata  <= w_pad_word;
        r_wdatav <= 1'b1;
      end else if (w_en) begin
        r_wdatav <= 1'b0;
      end
      if (w_drain) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sssp_update_packer.sv
// tb/tb_sssp_update_packer.sv - bench for sssp_update_packer
module tb_sssp_update_packer;

  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] L0 = 64'h00000001_00000000;
  localparam logic [63:0] L1 = 64'h00000002_00000001;
  localparam logic [63:0] L2 = 64'h00000002_00000003;
  localparam logic [63:0] L3 = 64'h00000004_00000003;
  localparam logic [63:0] A  = 64'h00000010_0000000A;
  localparam logic [63:0] B  = 64'h00000020_0000000B;
  localparam logic [63:0] J  = 64'hDEADBEEF_DEADBEEF;
  localparam logic [63:0] E0 = 64'h00000030_00000100;
  localparam logic [63:0] E1 = 64'h00000031_00000101;
  localparam logic [63:0] E2 = 64'h00000032_00000102;
  localparam logic [63:0] F0 = 64'h00000040_00000200;
  localparam logic [63:0] F1 = 64'h00000041_00000201;
  localparam logic [63:0] F2 = 64'h00000042_00000202;
  localparam logic [63:0] F3 = 64'h00000043_00000203;
  localparam logic [63:0] G0 = 64'h00000050_00000300;
  localparam logic [63:0] G1 = 64'h00000051_00000301;
  localparam logic [63:0] H0 = 64'h00000060_00000400;
  localparam logic [63:0] H1 = 64'h00000061_00000401;

  localparam logic [255:0] Z   = '0;
  localparam logic [255:0] D   = {L3, L2, L1, L0};
  localparam logic [255:0] SPD = {B, J, A, J};
  localparam logic [255:0] ED  = {J, E2, E1, E0};
  localparam logic [255:0] FD  = {F3, F2, F1, F0};
  localparam logic [255:0] GD  = {J, J, G1, G0};
  localparam logic [255:0] HD  = {J, J, H1, H0};

  localparam logic [511:0] WDD  = {D, D};
  localparam logic [511:0] WAB  = {B, A, B, A, B, A, B, A};
  localparam logic [511:0] WE   = {PAD, PAD, PAD, PAD, PAD, E2, E1, E0};
  localparam logic [511:0] WFGH = {H1, H0, G1, G0, FD};
  localparam logic [511:0] WDF  = {FD, D};

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] upd_data;
  logic [3:0]   upd_valid;
  logic         upd_ready;
  logic         w_en;
  logic [511:0] WData;
  logic         WDataV;
  logic         flush;
  logic         flush_done;
  logic [31:0]  word_cnt;

  always #5 clk = ~clk;

  sssp_update_packer #(
    .PIPE_NUM(4), .UPD_W(64), .OUT_W(512), .PAD_VAL(PAD), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .upd_data(upd_data), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .w_en(w_en), .WData(WData), .WDataV(WDataV),
    .flush(flush), .flush_done(flush_done), .word_cnt(word_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [3:0]   vld;
    logic [255:0] data;
    logic         wen;
    logic         fl;
    logic         erdy;
    logic         ev;
    logic         edone;
    logic [31:0]  ecnt;
    logic         cw;
    logic [511:0] ew;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [255:0] d, input logic we,
                     input logic f, input logic er, input logic ev, input logic ed,
                     input logic [31:0] ec, input logic cw, input logic [511:0] ew);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.wen = we; t.fl = f;
    t.erdy = er; t.ev = ev; t.edone = ed; t.ecnt = ec; t.cw = cw; t.ew = ew;
    tbl.push_back(t);
  endtask

  // Reference model state for the random phase.
  logic [63:0]  p_q[$];
  logic [511:0] exp_words[$];
  logic         bench_pend;
  logic [31:0]  mcnt;
  int           nflush;
  int           ndone;

  task automatic form_words(input logic pad_tail);
    logic [511:0] w;
    while (p_q.size() >= 8) begin
      for (int k = 0; k < 8; k++) w[k*64 +: 64] = p_q.pop_front();
      exp_words.push_back(w);
    end
    if (pad_tail && p_q.size() > 0) begin
      for (int k = 0; k < 8; k++) w[k*64 +: 64] = (p_q.size() > 0) ? p_q.pop_front() : PAD;
      exp_words.push_back(w);
    end
  endtask

  task automatic rnd_cycle();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = !bench_pend && (exp_words.size() == 0 || w_en);
    chk("rnd ready", 512'(upd_ready), 512'(exp_rdy));
    chk("rnd word_cnt", 512'(word_cnt), 512'(mcnt));
    if (!bench_pend) chk("rnd WDataV", 512'(WDataV), 512'(exp_words.size() != 0));
    if (WDataV && w_en) begin
      if (exp_words.size() == 0) chk("rnd extra word", 512'(WDataV), 512'(0));
      else begin
        chk("rnd word", WData, exp_words.pop_front());
        mcnt++;
      end
    end
    if (exp_rdy) begin
      for (int l = 0; l < 4; l++) if (upd_valid[l]) p_q.push_back(upd_data[l*64 +: 64]);
    end
    if (flush && !bench_pend) begin
      bench_pend = 1'b1;
      nflush++;
      form_words(1'b1);
    end else begin
      form_words(1'b0);
    end
    if (flush_done) begin
      if (!bench_pend) chk("rnd spurious flush_done", 512'(flush_done), 512'(0));
      else bench_pend = 1'b0;
      ndone++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dcount;
    rst = 1'b1; upd_valid = '0; upd_data = '0; w_en = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // lane ordering
    add(0, 4'hF, D,   1, 0, 1, 0, 0, 0, 1, '0);
    add(0, 4'hF, D,   1, 0, 1, 0, 0, 0, 0, '0);
    add(0, 4'h0, Z,   1, 0, 1, 1, 0, 0, 1, WDD);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 1, 0, '0);
    // sparse valid
    for (int i = 0; i < 4; i++) add(0, 4'b1010, SPD, 1, 0, 1, 0, 0, 1, 0, '0);
    // backpressure hold then release
    for (int i = 0; i < 5; i++) add(0, 4'h0, Z, 0, 0, 0, 1, 0, 1, 1, WAB);
    add(0, 4'h0, Z,   1, 0, 1, 1, 0, 1, 1, WAB);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 2, 0, '0);
    // partial flush
    add(0, 4'h7, ED,  1, 0, 1, 0, 0, 2, 0, '0);
    add(0, 4'h0, Z,   1, 1, 1, 0, 0, 2, 0, '0);
    add(0, 4'h0, Z,   1, 0, 0, 0, 0, 2, 0, '0);
    add(0, 4'h0, Z,   1, 0, 0, 1, 0, 2, 1, WE);
    add(0, 4'h0, Z,   1, 0, 0, 0, 1, 3, 0, '0);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 3, 0, '0);
    // empty flush
    add(0, 4'h0, Z,   1, 1, 1, 0, 0, 3, 0, '0);
    add(0, 4'h0, Z,   1, 0, 0, 0, 0, 3, 0, '0);
    add(0, 4'h0, Z,   1, 0, 0, 0, 1, 3, 0, '0);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 3, 0, '0);
    // flush together with the lanes that complete a word
    add(0, 4'hF, FD,  1, 0, 1, 0, 0, 3, 0, '0);
    add(0, 4'h3, GD,  1, 0, 1, 0, 0, 3, 0, '0);
    add(0, 4'h3, HD,  1, 1, 1, 0, 0, 3, 0, '0);
    add(0, 4'h0, Z,   1, 0, 0, 1, 0, 3, 1, WFGH);
    add(0, 4'h0, Z,   1, 0, 0, 0, 1, 4, 0, '0);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 4, 0, '0);
    // reset mid-fill
    add(0, 4'hF, FD,  1, 0, 1, 0, 0, 4, 0, '0);
    add(0, 4'h1, GD,  1, 0, 1, 0, 0, 4, 0, '0);
    add(1, 4'h0, Z,   1, 0, 1, 0, 0, 4, 0, '0);
    add(0, 4'hF, D,   1, 0, 1, 0, 0, 0, 0, '0);
    add(0, 4'hF, FD,  1, 0, 1, 0, 0, 0, 0, '0);
    add(0, 4'h0, Z,   1, 0, 1, 1, 0, 0, 1, WDF);
    add(0, 4'h0, Z,   1, 0, 1, 0, 0, 1, 0, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; upd_valid = tbl[i].vld; upd_data = tbl[i].data;
      w_en = tbl[i].wen; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d upd_ready", i), 512'(upd_ready), 512'(tbl[i].erdy));
      chk($sformatf("vec%0d WDataV", i), 512'(WDataV), 512'(tbl[i].ev));
      chk($sformatf("vec%0d flush_done", i), 512'(flush_done), 512'(tbl[i].edone));
      chk($sformatf("vec%0d word_cnt", i), 512'(word_cnt), 512'(tbl[i].ecnt));
      if (tbl[i].cw) chk($sformatf("vec%0d WData", i), WData, tbl[i].ew);
      @(posedge clk);
      #1;
    end

    // repeated flush while one is pending is ignored: exactly one done pulse and one word
    rst = 1'b0; w_en = 1'b1; upd_valid = 4'h7; upd_data = ED; flush = 1'b0;
    @(posedge clk); #1;
    upd_valid = '0; upd_data = '0;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      flush = (c < 3);
      @(negedge clk);
      if (flush_done) dcount++;
      @(posedge clk); #1;
    end
    flush = 1'b0;
    chk("repeat flush done count", 512'(dcount), 512'(1));
    chk("repeat flush word_cnt", 512'(word_cnt), 512'(2));

    // randomized stream against the queue model
    rst = 1'b1; upd_valid = '0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bench_pend = 1'b0; mcnt = '0; nflush = 0; ndone = 0;
    p_q.delete(); exp_words.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      upd_valid = 4'($urandom);
      for (int l = 0; l < 4; l++) upd_data[l*64 +: 64] = {$urandom, $urandom};
      w_en  = ($urandom_range(0, 3) != 0);
      flush = !bench_pend && ($urandom_range(0, 15) == 0);
      rnd_cycle();
    end
    upd_valid = '0; flush = 1'b0; w_en = 1'b1;
    for (int c = 0; c < 40 && (bench_pend || exp_words.size() != 0); c++) rnd_cycle();
    chk("drain flush pending", 512'(bench_pend), 512'(0));
    chk("drain words left", 512'(exp_words.size()), 512'(0));
    chk("flush vs done count", 512'(ndone), 512'(nflush));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sssp_update_packer.md
Name: sssp_update_packer

Overview:
- Parametrised write-side packer for the SSSP accelerator; generalises the single-pipe update path to PIPE_NUM parallel pipelines.
- Collects per-pipe 64-bit vertex updates and compacts them, lowest lane first, into 512-bit memory write words (WData0/WDataV0 style).
- Supports memory backpressure and an end-of-iteration flush that emits a partial word padded with invalid slots.
- Sits between the PIPE_NUM update pipelines and the memory write port.

Parameters:
- PIPE_NUM, 4, number of update input lanes; legal range 1..SLOTS.
- UPD_W, 64, update width; bits [63:32] destination vertex ID, bits [31:0] distance.
- OUT_W, 512, memory write word width; SLOTS = OUT_W/UPD_W = 8.
- PAD_VAL, 64'hFFFF_FFFF_FFFF_FFFF, filler written into unused slots on flush.
- CNT_W, 32, width of the emitted-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- upd_data  in  PIPE_NUM*UPD_W  lane i occupies bits [i*UPD_W +: UPD_W].
- upd_valid  in  PIPE_NUM  per-lane valid.
- upd_ready  out  1  common ready; all lanes accepted together.
- w_en  in  1  memory ready; the word is taken when WDataV and w_en are both high.
- WData  out  OUT_W  packed word; slot k occupies bits [k*UPD_W +: UPD_W].
- WDataV  out  1  WData valid.
- flush  in  1  single-cycle request to drain partial data.
- flush_done  out  1  single-cycle pulse when a flush completes.
- word_cnt  out  CNT_W  count of words accepted by memory since reset.

Behaviour:
- Reset: WDataV=0, WData=0, flush_done=0, word_cnt=0, accumulator count c=0, flush_pend=0. upd_ready=1 in the cycle after reset is released.
- Storage:
  - Accumulator of 2*SLOTS-1 slots with count c. Between cycles, c is always in 0..SLOTS-1.
  - One output register (WData/WDataV).
- Ready rule: upd_ready = !flush_pend && (!WDataV || w_en). The rule is combinational and contains no dependence on upd_valid.
- Accept rule:
  - An accept cycle is one with upd_ready=1.
  - The n lanes with upd_valid=1 (0..PIPE_NUM) are appended at slots c..c+n-1 in ascending lane order. Invalid lanes leave no gaps.
- Emit:
  - If c+n >= SLOTS, slots 0..SLOTS-1 load into WData and WDataV is set on the next edge.
  - The remaining c+n-SLOTS slots shift down to slot 0.
  - Latency: the word is visible one cycle after the accept cycle that completes it.
- Hold: while WDataV=1 and w_en=0, WData is stable and upd_ready=0.
- Drain:
  - WDataV=1 and w_en=1 increments word_cnt, wrapping modulo 2^CNT_W.
  - WDataV clears unless a new word loads in the same cycle; back-to-back words at full rate are required.
- Flush:
  - flush sets flush_pend. Lanes valid in the same cycle as flush, with upd_ready=1, are accepted before the flush takes effect.
  - flush while flush_pend=1 is ignored.
- Flush FSM states:
  - IDLE -> FLUSH on flush_pend.
  - FLUSH: when the output register is free (!WDataV || w_en) and c>0, load slots 0..c-1 plus PAD_VAL in slots c..SLOTS-1, then set c=0.
  - FLUSH -> WAIT when c=0.
  - WAIT: wait until WDataV=0, or until WDataV=1 and w_en=1 with no pending load.
  - WAIT -> DONE: flush_done=1 for one cycle, flush_pend clears, return to IDLE.
  - Flush with c=0 and WDataV=0 produces flush_done two cycles after the flush cycle and emits no word.
- Invariants:
  - Update order is preserved: lane order within a cycle, cycle order across cycles.
  - No update is lost or duplicated.
  - PAD_VAL appears only in flushed words.
- Reset mid-operation clears all buffered data and the pending flush. No partial word is emitted.
- PIPE_NUM=SLOTS with all lanes valid each cycle emits one word per cycle with c staying 0.

Test Plan:
- Lane ordering: PIPE_NUM=4, w_en=1, lanes 0..3 = 64'h00000001_00000000, 64'h00000002_00000001, 64'h00000002_00000003, 64'h00000004_00000003 for two cycles -> one word after cycle 2 with slots 0..3 and 4..7 each holding these values in lane order; word_cnt=1.
- Sparse valid: upd_valid=4'b1010 for 4 cycles (lane1=A, lane3=B) -> single word A,B,A,B,A,B,A,B; no gaps.
- Backpressure: full word pending with w_en=0 for 5 cycles -> WData stable, upd_ready=0 throughout; w_en=1 -> word_cnt+1 and upd_ready=1 in the same cycle.
- Flush partial: 3 updates then flush -> one word with slots 0..2 = data and slots 3..7 = PAD_VAL; flush_done pulses once after the memory accepts it.
- Flush empty / simultaneous: flush with c=0 -> flush_done in 2 cycles and no WDataV. flush with 2 valid lanes in the same cycle, c=6 -> one full word, then a padded word with 0 data slots suppressed, so exactly 1 word; flush_done pulses.
- Reset mid-fill: c=5, rst=1 for 1 cycle -> WDataV=0, word_cnt=0; the next 8 updates form a clean word.
